// File: rtl/unit_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : unit_share_arb                                             |
// | Description : Round-robin arbiter that shares one multi-cycle execution  |
// |               unit among N = 1<<LG_N requesters. One grant per           |
// |               operation; the owner is tracked while the unit is busy and |
// |               the unit's completion is routed back as a one-cycle        |
// |               rsp_valid pulse.                                           |
// | Optional    : ARB_WATCHDOG_EN - adds a BUSY watchdog (BUSY_MAX cycles)   |
// |               that abandons the owner and pulses timeout on expiry.      |
// | Ports       : clk, rst (sync, active-high)                               |
// |               req[N]       level requests, held until granted            |
// |               unit_ready   unit accepts a start this cycle               |
// |               unit_done    one-cycle completion pulse from the unit      |
// |               gnt[N]       one-hot grant pulse (with unit_start)         |
// |               gnt_id       {0,idx} on a grant, all ones otherwise        |
// |               unit_start   start pulse to the unit                       |
// |               rsp_valid[N] one-hot completion pulse to the owner         |
// |               busy         high while an operation is outstanding        |
// |               err          sticky: unit_done seen while not busy         |
// |               timeout      watchdog expiry pulse (0 without the macro)   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module unit_share_arb #(
  parameter int LG_N     = 2,
  parameter int BUSY_MAX = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [(1<<LG_N)-1:0] req,
  input  logic                unit_ready,
  input  logic                unit_done,
  output logic [(1<<LG_N)-1:0] gnt,
  output logic [LG_N:0]       gnt_id,
  output logic                unit_start,
  output logic [(1<<LG_N)-1:0] rsp_valid,
  output logic                busy,
  output logic                err,
  output logic                timeout
);

  localparam int c_n = 1 << LG_N;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [LG_N-1:0] r_ptr;
  logic [LG_N-1:0] w_ptr_nx;
  logic [LG_N-1:0] r_owner;
  logic [LG_N-1:0] w_owner_nx;
  logic            r_err;
  logic            w_err_nx;
  logic [LG_N-1:0] w_win;
  logic            w_win_vld;
  logic [LG_N-1:0] w_idx;
  logic            w_wd_expire;

  // Elaboration-time range check on the watchdog limit.
  generate
    if (BUSY_MAX < 2 || BUSY_MAX > 65535) begin : g_chk_busy_max
      $error("unit_share_arb: BUSY_MAX must be in 2..65535");
    end
  endgenerate

  // Round-robin search: first set request starting at r_ptr. The LG_N-bit
  // add wraps naturally, giving the mod-N search order.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < c_n; k++) begin
      w_idx = r_ptr + LG_N'(k);
      if (!w_win_vld && req[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [15:0] r_wd_cnt;

  assign w_wd_expire = (r_state == ST_BUSY) && !unit_done &&
                       (r_wd_cnt == 16'(BUSY_MAX - 1));

  // Cleared on the grant (entry to BUSY), counts BUSY cycles without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (unit_start) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_BUSY && !unit_done) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end
`else
  assign w_wd_expire = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_owner_nx = r_owner;
    gnt        = '0;
    gnt_id     = '1;
    unit_start = 1'b0;
    rsp_valid  = '0;
    busy       = 1'b0;
    timeout    = 1'b0;
    // A done with no operation outstanding is a protocol error.
    w_err_nx   = r_err | (unit_done && (r_state != ST_BUSY));

    case (r_state)
      ST_IDLE: begin
        if (w_win_vld && unit_ready) begin
          gnt[w_win] = 1'b1;
          gnt_id     = {1'b0, w_win};
          unit_start = 1'b1;
          w_owner_nx = w_win;
          w_ptr_nx   = w_win + LG_N'(1);
          w_state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        // A done in the expiry cycle takes priority over the watchdog.
        if (unit_done) begin
          rsp_valid[r_owner] = 1'b1;
          w_state_nx         = ST_IDLE;
        end else if (w_wd_expire) begin
          timeout    = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_owner <= w_owner_nx;
      r_err   <= w_err_nx;
    end
  end

  assign err = r_err;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_gnt_req:    assert property (@(posedge clk) disable iff (rst)
                                 (|gnt) |-> req[gnt_id[LG_N-1:0]]);

endmodule
`default_nettype wire

// File: tb/tb_unit_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_unit_share_arb                                          |
// | Description : Self-checking bench for unit_share_arb (N = 4). A table of |
// |               per-cycle {inputs, expected outputs} records is applied in |
// |               order, followed by a hand-written watchdog sequence whose  |
// |               expectations follow ARB_WATCHDOG_EN.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_unit_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       unit_ready;
  logic       unit_done;
  logic [3:0] gnt;
  logic [2:0] gnt_id;
  logic       unit_start;
  logic [3:0] rsp_valid;
  logic       busy;
  logic       err;
  logic       timeout;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  unit_share_arb #(.LG_N(2), .BUSY_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .unit_ready (unit_ready),
    .unit_done  (unit_done),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .unit_start (unit_start),
    .rsp_valid  (rsp_valid),
    .busy       (busy),
    .err        (err),
    .timeout    (timeout)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       done;
    logic [3:0] gnt;
    logic [2:0] gid;
    logic       start;
    logic [3:0] rsp;
    logic       busy;
    logic       err;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  localparam logic [2:0] NO = 3'b111;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rd,
                              input logic dn, input logic [3:0] g, input logic [2:0] gi,
                              input logic st, input logic [3:0] rs, input logic b,
                              input logic e, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.rdy = rd; v.done = dn;
    v.gnt = g; v.gid = gi; v.start = st; v.rsp = rs;
    v.busy = b; v.err = e; v.to = t;
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, check just after.
  task automatic apply(input vec_t v, input string name);
    logic [14:0] act, exp;
    @(negedge clk);
    rst        = v.rst;
    req        = v.req;
    unit_ready = v.rdy;
    unit_done  = v.done;
    #1;
    act = {gnt, gnt_id, unit_start, rsp_valid, busy, err, timeout};
    exp = {v.gnt, v.gid, v.start, v.rsp, v.busy, v.err, v.to};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got gnt=%b id=%b start=%b rsp=%b busy=%b err=%b to=%b, want gnt=%b id=%b start=%b rsp=%b busy=%b err=%b to=%b",
               name, gnt, gnt_id, unit_start, rsp_valid, busy, err, timeout,
               v.gnt, v.gid, v.start, v.rsp, v.busy, v.err, v.to);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; unit_ready = 1'b0; unit_done = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then single requester: grant cycle 0, done cycle 4.
    tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, NO,     0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 1, 0, 4'b0001, 3'b000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 0, 0));
    // Rotation from ptr=0 with all four requesting: 0,1,2,3,0.
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(0, 4'b1111, 1, 0, 4'(1 << k), 3'(k), 1, 4'b0000, 0, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0000, NO, 0, 4'b0000, 1, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b0000, NO, 0, 4'(1 << k), 1, 0, 0));
    end
    tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0001, 3'b000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0001, 1, 0, 0));
    // Wrap search with req=0101 from ptr=1: 2, then 0 (wrap from 3), then 2.
    tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0100, 3'b010, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 1, 4'b0000, NO,     0, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0001, 3'b000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 1, 4'b0000, NO,     0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0100, 3'b010, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0100, 1, 0, 0));
    // unit_ready low for 5 cycles blocks the grant; then grant 1 (ptr=3 wraps).
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 4'b0010, 0, 0, 4'b0000, NO, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 1, 0, 4'b0010, 3'b001, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0010, 1, 0, 0));
    // Spurious done in IDLE: no response, err sticky; a grant is not blocked.
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 1, 1, 4'b0100, 3'b010, 1, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 0, 0));
    // Reset mid-BUSY drops the owner; the later done only sets err.
    tbl.push_back(mk(0, 4'b0001, 1, 0, 4'b0001, 3'b000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, NO,     0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, NO,     0, 4'b0000, 0, 1, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Watchdog sequence: grant requester 0 and never complete for 12 cycles.
    apply(mk(0, 4'b0001, 1, 0, 4'b0001, 3'b000, 1, 4'b0000, 0, 0, 0), "wd_grant");
    for (int i = 0; i < 12; i++) begin
`ifdef ARB_WATCHDOG_EN
      // BUSY cycles 1..8; the 8th (i==7) pulses timeout, IDLE afterwards.
      apply(mk(0, 4'b0000, 1, 0, 4'b0000, NO, 0, 4'b0000,
               (i <= 7), 0, (i == 7)), $sformatf("wd_cycle%0d", i));
`else
      apply(mk(0, 4'b0000, 1, 0, 4'b0000, NO, 0, 4'b0000, 1, 0, 0),
            $sformatf("wd_cycle%0d", i));
`endif
    end
`ifdef ARB_WATCHDOG_EN
    apply(mk(0, 4'b0000, 1, 1, 4'b0000, NO, 0, 4'b0000, 0, 0, 0), "wd_late_done");
    apply(mk(0, 4'b0000, 1, 0, 4'b0000, NO, 0, 4'b0000, 0, 1, 0), "wd_late_err");
`else
    apply(mk(0, 4'b0000, 1, 1, 4'b0000, NO, 0, 4'b0001, 1, 0, 0), "wd_done");
    apply(mk(0, 4'b0000, 1, 0, 4'b0000, NO, 0, 4'b0000, 0, 0, 0), "wd_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
